// File: rtl/irq_controller.sv
// Interrupt controller: edge-captured external sources, fixed priority, request/ack/done handshake.
// Define IRQC_TIMER_EN to add the mtime/mtimecmp machine timer as the highest-priority source.
module irq_controller #(
  parameter int unsigned NUM_SRC   = 8,
  parameter int unsigned TIMER_DIV = 1
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [NUM_SRC-1:0] IRQ_SRC,
  input  logic [NUM_SRC-1:0] IRQ_ENABLE,
  input  logic               IE,
  input  logic               IRQ_ACK,
  input  logic               IRQ_DONE,
  input  logic               MTIE,
  input  logic               MTIMECMP_WE,
  input  logic [63:0]        MTIMECMP_WDATA,
  output logic               INTERRUPT,
  output logic [63:0]        IRQ_CAUSE,
  output logic [63:0]        MTIME
);

  localparam logic [63:0] CauseIrq = 64'h8000_0000_0000_0000;

  typedef enum logic [1:0] {StIdle, StReq, StService} state_e;

  state_e               state_q;
  logic [NUM_SRC-1:0]   sync1_q, sync2_q, sync3_q, pending_q, pending_d;
  logic [NUM_SRC-1:0]   cand, rise, win_oh, cur_oh_q;
  logic [63:0]          win_cause;
  logic                 win_timer, win_valid, cur_timer_q, mask_ok, take;
  logic                 timer_pend, timer_en;

`ifdef IRQC_TIMER_EN
  logic [63:0] mtime_q, mtimecmp_q;
  logic [31:0] div_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      div_q      <= '0;
    end else begin
      if (div_q == TIMER_DIV - 1) begin
        div_q   <= '0;
        mtime_q <= mtime_q + 64'd1;
      end else begin
        div_q <= div_q + 32'd1;
      end
      if (MTIMECMP_WE) mtimecmp_q <= MTIMECMP_WDATA;
    end
  end

  assign timer_pend = MTIE && (mtime_q >= mtimecmp_q);
  assign timer_en   = MTIE;
  assign MTIME      = mtime_q;
`else
  logic unused_timer;
  assign unused_timer = ^{MTIE, MTIMECMP_WE, MTIMECMP_WDATA, TIMER_DIV[0]};
  assign timer_pend   = 1'b0;
  assign timer_en     = 1'b0;
  assign MTIME        = '0;
`endif

  // Rising edge seen after the two synchroniser stages.
  assign rise = sync2_q & ~sync3_q;
  assign cand = pending_q & IRQ_ENABLE;
  assign take = (state_q == StReq) && IRQ_ACK;

  // A new edge in the same cycle as the ack clear keeps the source pending.
  assign pending_d = (pending_q & ~(take ? cur_oh_q : '0)) | rise;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      sync3_q   <= '0;
      pending_q <= '0;
    end else begin
      sync1_q   <= IRQ_SRC;
      sync2_q   <= sync1_q;
      sync3_q   <= sync2_q;
      pending_q <= pending_d;
    end
  end

  // Descending scan so the lowest index overwrites; the timer beats everything.
  always_comb begin
    win_oh    = '0;
    win_timer = 1'b0;
    win_cause = '0;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (cand[i]) begin
        win_oh    = '0;
        win_oh[i] = 1'b1;
        win_cause = CauseIrq | 64'(16 + i);
      end
    end
    if (timer_pend) begin
      win_oh    = '0;
      win_timer = 1'b1;
      win_cause = CauseIrq | 64'd7;
    end
  end

  assign win_valid = (|cand) | timer_pend;
  assign mask_ok   = cur_timer_q ? timer_en : |(cur_oh_q & IRQ_ENABLE);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= StIdle;
      INTERRUPT   <= 1'b0;
      IRQ_CAUSE   <= '0;
      cur_oh_q    <= '0;
      cur_timer_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (IE && win_valid) begin
            state_q     <= StReq;
            INTERRUPT   <= 1'b1;
            IRQ_CAUSE   <= win_cause;
            cur_oh_q    <= win_oh;
            cur_timer_q <= win_timer;
          end
        end
        StReq: begin
          if (IRQ_ACK) begin
            state_q   <= StService;
            INTERRUPT <= 1'b0;
          end else if (!IE || !mask_ok) begin
            state_q   <= StIdle;
            INTERRUPT <= 1'b0;
          end
        end
        StService: begin
          if (IRQ_DONE) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Scoreboard bench for irq_controller: expected {INTERRUPT, IRQ_CAUSE} queued per cycle as
// stimulus is driven, popped and compared by a negedge monitor.
module tb_irq_controller;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [7:0]  src, en;
  logic        ie, ack, done, mtie, we;
  logic [63:0] wdata;
  logic        INTERRUPT;
  logic [63:0] IRQ_CAUSE, MTIME;

  irq_controller #(.NUM_SRC(8), .TIMER_DIV(1)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .IRQ_SRC       (src),
    .IRQ_ENABLE    (en),
    .IE            (ie),
    .IRQ_ACK       (ack),
    .IRQ_DONE      (done),
    .MTIE          (mtie),
    .MTIMECMP_WE   (we),
    .MTIMECMP_WDATA(wdata),
    .INTERRUPT     (INTERRUPT),
    .IRQ_CAUSE     (IRQ_CAUSE),
    .MTIME         (MTIME)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          cyc;
    string       tag;
    logic [64:0] exp;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  function automatic logic [63:0] cause(input int code);
    return 64'h8000_0000_0000_0000 | 64'(code);
  endfunction

  task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input int off, input logic irq, input logic [63:0] c);
    exp_t e;
    e.cyc = cyc + off;
    e.tag = tag;
    e.exp = {irq, c};
    sbq.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      mon_e = sbq.pop_front();
      check(mon_e.tag, {INTERRUPT, IRQ_CAUSE}, mon_e.exp);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    RESET = 1'b1; src = '0; en = 8'hFF; ie = 1'b1; ack = 1'b0; done = 1'b0;
    mtie = 1'b0; we = 1'b0; wdata = '0;
    tick(2);
    check("rst_out", {INTERRUPT, IRQ_CAUSE}, 65'd0);
    check("rst_mtime", {1'b0, MTIME}, 65'd0);
    RESET = 1'b0;
    tick(2);

    // Single source 2; ack with IE dropping in the same cycle (ack must win).
    src = 8'h04;
    push("s1_pre", 3, 1'b0, 64'd0);
    push("s1_req", 4, 1'b1, cause(18));
    tick(1); src = '0;
    tick(3); ack = 1'b1; ie = 1'b0;
    push("s1_ack", 1, 1'b0, cause(18));
    tick(1); ack = 1'b0; ie = 1'b1;
    tick(2); done = 1'b1;
    push("s1_clr", 3, 1'b0, cause(18));
    tick(1); done = 1'b0;
    tick(4);

    // Sources 5 and 1 together; re-edge on 5 coincides with its ack clear.
    src = 8'h22;
    push("s2_req1", 4, 1'b1, cause(17));
    tick(1); src = '0;
    tick(3); ack = 1'b1;
    push("s2_ack1", 1, 1'b0, cause(17));
    tick(1); ack = 1'b0; done = 1'b1; src = 8'h20;
    push("s2_svc1", 1, 1'b0, cause(17));
    push("s2_req5", 2, 1'b1, cause(21));
    tick(1); done = 1'b0; src = '0;
    tick(1); ack = 1'b1;
    push("s2_ack5", 1, 1'b0, cause(21));
    tick(1); ack = 1'b0; done = 1'b1;
    push("s2_svc5", 1, 1'b0, cause(21));
    push("s2_sticky", 2, 1'b1, cause(21));
    tick(1); done = 1'b0;
    tick(1); ack = 1'b1;
    push("s2_ack5b", 1, 1'b0, cause(21));
    tick(1); ack = 1'b0; done = 1'b1;
    push("s2_quiet", 3, 1'b0, cause(21));
    tick(1); done = 1'b0;
    tick(3);

    // Global mask, withdraw by per-source mask, then no nesting while in service.
    ie = 1'b0; src = 8'h08;
    tick(1); src = '0;
    tick(4);
    push("s3_masked", 0, 1'b0, cause(21));
    ie = 1'b1;
    push("s3_ie", 1, 1'b1, cause(19));
    tick(1); en = 8'hF7;
    push("s3_withdraw", 1, 1'b0, cause(19));
    tick(3);
    push("s3_retain", 0, 1'b0, cause(19));
    en = 8'hFF;
    push("s3_rereq", 1, 1'b1, cause(19));
    tick(1); ack = 1'b1;
    push("s3_ack", 1, 1'b0, cause(19));
    tick(1); ack = 1'b0; src = 8'h01;
    push("s3_nonest", 5, 1'b0, cause(19));
    tick(1); src = '0;
    tick(5); done = 1'b1;
    push("s3_done", 1, 1'b0, cause(19));
    push("s3_src0", 2, 1'b1, cause(16));
    tick(1); done = 1'b0;
    tick(2);

    // Reset while requesting.
    RESET = 1'b1;
    #1;
    check("rst_mid_req", {INTERRUPT, IRQ_CAUSE}, 65'd0);
    tick(2); RESET = 1'b0;
    tick(6);
    push("rst_no_req", 0, 1'b0, 64'd0);
    tick(1);

`ifdef IRQC_TIMER_EN
    en = '0; we = 1'b1; wdata = 64'd20; mtie = 1'b1;
    tick(1); we = 1'b0;
    for (int i = 0; i < 60 && INTERRUPT !== 1'b1; i++) tick(1);
    check("tmr_req", {INTERRUPT, IRQ_CAUSE}, {1'b1, cause(7)});
    check("tmr_mtime", {64'd0, MTIME >= 64'd20}, 65'd1);
    ack = 1'b1;
    tick(1); ack = 1'b0; done = 1'b1;
    tick(1); done = 1'b0;
    for (int i = 0; i < 10 && INTERRUPT !== 1'b1; i++) tick(1);
    check("tmr_rereq", {INTERRUPT, IRQ_CAUSE}, {1'b1, cause(7)});
    we = 1'b1; wdata = 64'd1000; ack = 1'b1;
    tick(1); we = 1'b0; ack = 1'b0; done = 1'b1;
    tick(1); done = 1'b0;
    tick(5);
    check("tmr_cleared", {INTERRUPT, IRQ_CAUSE}, {1'b0, cause(7)});
`else
    check("mtime_tied", {1'b0, MTIME}, 65'd0);
`endif

    tick(2);
    check("drain", 65'(sbq.size()), 65'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
